// File: rtl/npc_ctrl.sv
// npc_ctrl: computer-opponent controller for the left half of the court.
// Tracks the ball horizontally with a per-difficulty step and doze duty cycle,
// and performs a tick-based parabolic jump through a four-state vertical FSM.
// All motion advances on an internal physics tick every TICK_DIV clocks.
// Optional feature macro: NPC_JITTER_EN (adds an 8-bit LFSR aim jitter of 0..3 px).
module npc_ctrl #(
   parameter int COURT_H      = 240,
   parameter int NET_X        = 160,
   parameter int NPC_W        = 41,
   parameter int NPC_H        = 42,
   parameter int FLOOR_MARGIN = 20,
   parameter int BALL_DIST    = 18,
   parameter int DEADBAND     = 2,
   parameter int JUMP_TRIG_Y  = 80,
   parameter int JUMP_RANGE   = 24,
   parameter int JUMP_V0      = 12,
   parameter int GRAVITY      = 1,
   parameter int VMAX         = 15,
   parameter int LAND_TICKS   = 3,
   parameter int TICK_DIV     = 1666667,
   parameter int DOZE_PERIOD  = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] ball_pos_x,
   input  logic [11:0] ball_pos_y,
   input  logic [1:0]  difficulty,
   input  logic [1:0]  game_state,
   output logic [11:0] npc_pos_x,
   output logic [11:0] npc_pos_y,
   output logic [1:0]  npc_state
);

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2,
      ST_LAND   = 2'd3
   } vstate_e;

   localparam int GROUND_Y = COURT_H - NPC_H - FLOOR_MARGIN;
   localparam int X_MAX    = NET_X - NPC_W;
   localparam int TW       = $clog2(TICK_DIV);
   localparam int DW       = (DOZE_PERIOD > 1) ? $clog2(DOZE_PERIOD) : 1;
   localparam int LW       = (LAND_TICKS > 1) ? $clog2(LAND_TICKS + 1) : 1;

   localparam logic [9:0]         GROUND_Y_V = 10'(GROUND_Y);
   localparam logic [11:0]        X_MAX_V    = 12'(X_MAX);
   localparam logic [11:0]        TRIG_Y_V   = 12'(JUMP_TRIG_Y);
   localparam logic [4:0]         V0_V       = 5'(JUMP_V0);
   localparam logic [4:0]         GRAV_V     = 5'(GRAVITY);
   localparam logic [4:0]         VMAX_V     = 5'(VMAX);
   localparam logic signed [12:0] DB_V       = 13'(DEADBAND);
   localparam logic signed [12:0] JR_V       = 13'(JUMP_RANGE);
   localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0]      DOZE_LAST  = DW'(DOZE_PERIOD - 1);
   localparam logic [LW-1:0]      LAND_INIT  = LW'(LAND_TICKS);
   localparam logic [DW:0]        AWAKE_0    = (DW+1)'(DOZE_PERIOD);
   localparam logic [DW:0]        AWAKE_1    = (DW+1)'(DOZE_PERIOD * 3 / 4);
   localparam logic [DW:0]        AWAKE_2    = (DW+1)'(DOZE_PERIOD / 2);
   localparam logic [DW:0]        AWAKE_3    = (DW+1)'(DOZE_PERIOD / 4);

   logic [TW-1:0]        tick_cnt;
   logic                 tick;
   logic                 reinit;
   vstate_e              state, state_nxt;
   logic [11:0]          x, x_nxt;
   logic [9:0]           y, y_nxt;
   logic [4:0]           vel, vel_nxt;
   logic [LW-1:0]        land_cnt, land_nxt;
   logic [DW-1:0]        doze_cnt, doze_nxt;
   logic [1:0]           jit;
   logic [12:0]          ref_x;
   logic signed [12:0]   diff;
   logic [DW:0]          awake_lim;
   logic                 awake;
   logic [11:0]          step;
   logic [11:0]          x_up;
   logic                 jump_ok;
   logic [9:0]           y_rise;
   logic [5:0]           vel_sum;
   logic [4:0]           vel_fall;
   logic [10:0]          y_fall;

   assign tick   = (tick_cnt == TICK_LAST);
   assign reinit = (game_state == 2'd1);

   // Free-running physics tick divider, restarted by reinit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tick_cnt <= '0;
      else if (reinit || tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + TW'(1);
   end

`ifdef NPC_JITTER_EN
   logic [7:0] lfsr;
   logic       lfsr_fb;

   assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign jit     = lfsr[1:0];

   // Fibonacci LFSR giving a small aim jitter, advanced once per tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         lfsr <= 8'hA5;
      else if (reinit)
         lfsr <= 8'hA5;
      else if (tick)
         lfsr <= {lfsr[6:0], lfsr_fb};
   end
`else
   assign jit = 2'b00;
`endif

   // Aim reference and signed distance from the ball; 13 bits so nothing wraps.
   assign ref_x = {1'b0, x} + 13'(BALL_DIST) + {11'b0, jit};
   assign diff  = $signed({1'b0, ball_pos_x}) - $signed(ref_x);

   // Per-difficulty awake window and horizontal step size.
   always_comb begin
      awake_lim = AWAKE_3;
      step      = 12'd1;
      case (difficulty)
         2'd0: begin awake_lim = AWAKE_0; step = 12'd3; end
         2'd1: begin awake_lim = AWAKE_1; step = 12'd2; end
         2'd2: begin awake_lim = AWAKE_2; step = 12'd1; end
         default: begin awake_lim = AWAKE_3; step = 12'd1; end
      endcase
   end

   assign awake   = ({1'b0, doze_cnt} < awake_lim);
   assign x_up    = x + step;
   assign jump_ok = awake && (ball_pos_y <= TRIG_Y_V) && (diff <= JR_V) && (diff >= -JR_V);

   assign y_rise   = (y <= {5'b0, vel}) ? 10'd0 : (y - {5'b0, vel});
   assign vel_sum  = {1'b0, vel} + {1'b0, GRAV_V};
   assign vel_fall = (vel_sum > {1'b0, VMAX_V}) ? VMAX_V : vel_sum[4:0];
   assign y_fall   = {1'b0, y} + {6'b0, vel_fall};

   // Next-state logic: reinit overrides, otherwise everything advances on tick.
   always_comb begin
      x_nxt     = x;
      y_nxt     = y;
      vel_nxt   = vel;
      state_nxt = state;
      land_nxt  = land_cnt;
      doze_nxt  = doze_cnt;
      if (reinit) begin
         x_nxt     = 12'd1;
         y_nxt     = GROUND_Y_V;
         vel_nxt   = 5'd0;
         state_nxt = ST_GROUND;
         land_nxt  = '0;
         doze_nxt  = '0;
      end else if (tick) begin
         doze_nxt = (doze_cnt == DOZE_LAST) ? '0 : (doze_cnt + DW'(1));
         if (awake) begin
            if (diff > DB_V)
               x_nxt = (x_up > X_MAX_V) ? X_MAX_V : x_up;
            else if (diff < -DB_V)
               x_nxt = (x < step) ? 12'd0 : (x - step);
         end
         case (state)
            ST_GROUND: begin
               y_nxt = GROUND_Y_V;
               if (jump_ok) begin
                  state_nxt = ST_RISE;
                  vel_nxt   = V0_V;
               end
            end
            ST_RISE: begin
               y_nxt = y_rise;
               if (vel <= GRAV_V) begin
                  vel_nxt   = 5'd0;
                  state_nxt = ST_FALL;
               end else begin
                  vel_nxt = vel - GRAV_V;
               end
            end
            ST_FALL: begin
               vel_nxt = vel_fall;
               if (y_fall >= {1'b0, GROUND_Y_V}) begin
                  y_nxt     = GROUND_Y_V;
                  land_nxt  = LAND_INIT;
                  state_nxt = ST_LAND;
               end else begin
                  y_nxt = y_fall[9:0];
               end
            end
            default: begin
               if (land_cnt <= LW'(1)) begin
                  land_nxt  = '0;
                  state_nxt = ST_GROUND;
               end else begin
                  land_nxt = land_cnt - LW'(1);
               end
            end
         endcase
      end
   end

   // Position, velocity and vertical-FSM state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x        <= 12'd1;
         y        <= GROUND_Y_V;
         vel      <= 5'd0;
         state    <= ST_GROUND;
         land_cnt <= '0;
         doze_cnt <= '0;
      end else begin
         x        <= x_nxt;
         y        <= y_nxt;
         vel      <= vel_nxt;
         state    <= state_nxt;
         land_cnt <= land_nxt;
         doze_cnt <= doze_nxt;
      end
   end

   assign npc_pos_x = x;
   assign npc_pos_y = {2'b00, y};
   assign npc_state = state;

endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl: scoreboard bench for npc_ctrl with a behavioural reference model.
// Stimulus is driven just after each falling edge and the expected outputs after
// the following rising edge are queued; a monitor pops and compares on every
// falling edge.
module tb_npc_ctrl;

   localparam int TD       = 4;
   localparam int GROUND_Y = 240 - 42 - 20;
   localparam int X_MAX    = 160 - 41;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] ball_pos_x = 12'd0;
   logic [11:0] ball_pos_y = 12'd200;
   logic [1:0]  difficulty = 2'd0;
   logic [1:0]  game_state = 2'd0;
   logic [11:0] npc_pos_x;
   logic [11:0] npc_pos_y;
   logic [1:0]  npc_state;

   typedef struct {
      int x;
      int y;
      int st;
   } exp_t;

   exp_t expq[$];
   int   total = 0;
   int   bad = 0;

   int m_x = 1, m_y = GROUND_Y, m_vel = 0, m_st = 0, m_land = 0;
   int m_doze = 0, m_tick = 0, m_lfsr = 8'hA5;

   npc_ctrl #(.TICK_DIV(TD)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ball_pos_x (ball_pos_x),
      .ball_pos_y (ball_pos_y),
      .difficulty (difficulty),
      .game_state (game_state),
      .npc_pos_x  (npc_pos_x),
      .npc_pos_y  (npc_pos_y),
      .npc_state  (npc_state)
   );

   always #5 clk = ~clk;

   function automatic int awakeLimit(input int d);
      case (d)
         0: return 64;
         1: return 48;
         2: return 32;
         default: return 16;
      endcase
   endfunction

   function automatic int stepSize(input int d);
      case (d)
         0: return 3;
         1: return 2;
         default: return 1;
      endcase
   endfunction

   task automatic checkOutput(input string name, input int ex, input int ey, input int est);
      total++;
      if (npc_pos_x !== 12'(ex) || npc_pos_y !== 12'(ey) || npc_state !== 2'(est)) begin
         bad++;
         $display("[TB] FAIL %s @%0t: got x=%0d y=%0d st=%0d, want x=%0d y=%0d st=%0d",
                  name, $time, npc_pos_x, npc_pos_y, npc_state, ex, ey, est);
      end
   endtask

   task automatic modelReinit();
      m_x = 1; m_y = GROUND_Y; m_vel = 0; m_st = 0; m_land = 0;
      m_doze = 0; m_tick = 0; m_lfsr = 8'hA5;
   endtask

   task automatic modelTick(input int bx, input int by, input int dif);
      int  jit;
      int  d;
      int  fb;
      bit  awake;
      jit = 0;
`ifdef NPC_JITTER_EN
      jit = m_lfsr & 3;
`endif
      d = bx - (m_x + 18 + jit);
      awake = (m_doze < awakeLimit(dif));
      if (awake) begin
         if (d > 2)
            m_x = (m_x + stepSize(dif) > X_MAX) ? X_MAX : m_x + stepSize(dif);
         else if (d < -2)
            m_x = (m_x - stepSize(dif) < 0) ? 0 : m_x - stepSize(dif);
      end
      case (m_st)
         0: begin
            m_y = GROUND_Y;
            if (awake && by <= 80 && d <= 24 && d >= -24) begin
               m_st = 1;
               m_vel = 12;
            end
         end
         1: begin
            m_y = (m_y - m_vel < 0) ? 0 : m_y - m_vel;
            if (m_vel <= 1) begin
               m_vel = 0;
               m_st = 2;
            end else begin
               m_vel = m_vel - 1;
            end
         end
         2: begin
            m_vel = (m_vel + 1 > 15) ? 15 : m_vel + 1;
            if (m_y + m_vel >= GROUND_Y) begin
               m_y = GROUND_Y;
               m_land = 3;
               m_st = 3;
            end else begin
               m_y = m_y + m_vel;
            end
         end
         default: begin
            m_land = m_land - 1;
            if (m_land <= 0) begin
               m_land = 0;
               m_st = 0;
            end
         end
      endcase
      m_doze = (m_doze + 1) % 64;
      fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
      m_lfsr = ((m_lfsr << 1) | fb) & 255;
   endtask

   task automatic modelEdge(input bit rst, input int gs, input int bx, input int by, input int dif);
      if (!rst) begin
         modelReinit();
      end else if (gs == 1) begin
         modelReinit();
      end else if (m_tick == TD - 1) begin
         m_tick = 0;
         modelTick(bx, by, dif);
      end else begin
         m_tick++;
      end
   endtask

   task automatic applyStimulus(input bit rst, input int gs, input int bx, input int by, input int dif);
      bit   wasHigh;
      exp_t e;
      @(negedge clk);
      #1;
      wasHigh    = reset_n;
      reset_n    = rst;
      game_state = 2'(gs);
      ball_pos_x = 12'(bx);
      ball_pos_y = 12'(by);
      difficulty = 2'(dif);
      if (wasHigh && !rst) begin
         #1;
         checkOutput("async_reset", 1, GROUND_Y, 0);
      end
      modelEdge(rst, gs, bx, by, dif);
      e.x = m_x;
      e.y = m_y;
      e.st = m_st;
      expq.push_back(e);
   endtask

   task automatic runCycles(input int n, input bit rst, input int gs, input int bx, input int by, input int dif);
      for (int i = 0; i < n; i++)
         applyStimulus(rst, gs, bx, by, dif);
   endtask

   // Monitor: compare the DUT outputs against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         checkOutput("cycle", e.x, e.y, e.st);
      end
   end

   // Stimulus sequence: directed scenarios followed by randomized traffic.
   initial begin
      int bx, by, dif, gs, hold, r;
      bit rst;

      runCycles(3, 0, 0, 300, 200, 0);
      runCycles(200, 1, 0, 300, 200, 0);
      runCycles(200, 1, 0, 20, 200, 0);

      runCycles(2, 1, 0, 300, 200, 0);
      runCycles(3, 0, 0, 300, 200, 0);
      runCycles(12, 1, 0, 300, 200, 0);

      runCycles(2, 1, 1, 58, 200, 0);
      runCycles(80, 1, 0, 58, 200, 0);
      runCycles(130, 1, 0, 58, 60, 0);

      runCycles(2, 1, 1, 58, 200, 0);
      runCycles(80, 1, 0, 58, 200, 0);
      runCycles(22, 1, 0, 58, 60, 0);
      runCycles(1, 1, 1, 58, 60, 0);
      runCycles(30, 1, 0, 58, 200, 0);

      runCycles(2, 1, 1, 19, 81, 0);
      runCycles(40, 1, 0, 19, 81, 0);
      runCycles(2, 1, 1, 44, 80, 0);
      runCycles(40, 1, 0, 44, 80, 0);
      runCycles(2, 1, 1, 43, 80, 0);
      runCycles(40, 1, 0, 43, 80, 0);

      runCycles(2, 1, 1, 300, 200, 3);
      runCycles(TD * 140, 1, 0, 300, 200, 3);

      runCycles(2, 1, 1, 300, 200, 0);
      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 29) == 0) begin
            gs = 1;
         end else begin
            r = int'($urandom_range(0, 2));
            gs = (r == 0) ? 0 : r + 1;
         end
         if ($urandom_range(0, 1) == 1) begin
            bx = int'($urandom_range(0, 4095));
         end else begin
            bx = m_x + 18 + int'($urandom_range(0, 60)) - 30;
            if (bx < 0) bx = 0;
         end
         by   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4095)) : int'($urandom_range(60, 100));
         dif  = int'($urandom_range(0, 3));
         hold = int'($urandom_range(1, 8));
         runCycles(hold, rst, gs, bx, by, dif);
      end

      @(negedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
